// File: rtl/stack_ctrl_mc.sv
// ============================================================================
// Module   : stack_ctrl_mc
// Purpose  : Multicycle controller for the stack-based MIPS core. Decodes an
//            OPW-bit opcode and sequences PC, memory, stack and ALU controls,
//            with a memory ready/timeout handshake, stack depth checks and
//            sticky HALT/TRAP states.
// Options  : STACK_CTRL_PERF_EN - when defined, builds a 32-bit retired
//            instruction counter on o_instret; otherwise o_instret is 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ctrl_mc #(
  parameter int OPW    = 4,
  parameter int MEM_TO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_mem_ready,
  input  logic           i_a_zero,
  input  logic           i_stk_empty,
  input  logic           i_stk_single,
  input  logic           i_stk_full,
  output logic           o_pc_next,
  output logic           o_pc_jump,
  output logic           o_pc_ld,
  output logic           o_lord,
  output logic           o_mr,
  output logic           o_mw,
  output logic           o_ir_ld,
  output logic [1:0]     o_stack_src,
  output logic           o_tos,
  output logic           o_reg_dst,
  output logic           o_push,
  output logic           o_pop,
  output logic           o_la,
  output logic           o_lb,
  output logic           o_ain,
  output logic           o_bin,
  output logic [2:0]     o_alu_op,
  output logic           o_halted,
  output logic           o_trap,
  output logic [1:0]     o_trap_code,
  output logic [31:0]    o_instret
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_POPA = 4'd2,
    S_SP   = 4'd3,
    S_ALU  = 4'd4,
    S_POPN = 4'd5,
    S_NALU = 4'd6,
    S_SAVE = 4'd7,
    S_MRD  = 4'd8,
    S_MWR  = 4'd9,
    S_JMP  = 4'd10,
    S_JZ   = 4'd11,
    S_DUP  = 4'd12,
    S_HALT = 4'd13,
    S_TRAP = 4'd14
  } state_t;

  // Counter only has to reach MEM_TO-1 before the trap fires.
  localparam int              c_TW      = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(MEM_TO - 1);

  state_t          r_state;
  state_t          w_next;
  logic [c_TW-1:0] r_to_cnt;
  logic [1:0]      r_trap_code;
  logic [1:0]      w_tcode;
  logic            w_hi_nz;
  logic [3:0]      w_op4;
  logic            w_illegal;
  logic            w_is_bin;
  logic            w_under;
  logic            w_over;
  logic            w_wait_st;
  logic            w_to_hit;

  // Any set bit above bit 3 makes the opcode illegal.
  if (OPW > 4) begin : g_hi_bits
    assign w_hi_nz = |i_opcode[OPW-1:4];
  end else begin : g_no_hi_bits
    assign w_hi_nz = 1'b0;
  end

  assign w_op4     = i_opcode[3:0];
  assign w_is_bin  = (w_op4[3:2] == 2'b00);
  assign w_illegal = w_hi_nz || ((w_op4 >= 4'd10) && (w_op4 <= 4'd14));
  assign w_under   = (w_is_bin && (i_stk_empty || i_stk_single)) ||
                     (((w_op4 == 4'd4) || (w_op4 == 4'd6) ||
                       (w_op4 == 4'd8) || (w_op4 == 4'd9)) && i_stk_empty);
  assign w_over    = ((w_op4 == 4'd5) || (w_op4 == 4'd9)) && i_stk_full;

  assign w_wait_st = (r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR);
  // Ready in the final allowed cycle still wins over the timeout.
  assign w_to_hit  = (MEM_TO != 0) && (r_to_cnt == c_TO_LAST) && !i_mem_ready;

  assign o_trap_code = r_trap_code;

  // State register; reset drops straight back to instruction fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  // Memory stall counter: cleared on every state change, counts stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_to_cnt <= '0;
    else if (w_next != r_state)             r_to_cnt <= '0;
    else if (w_wait_st && !i_mem_ready)     r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Capture the trap cause once, on entry to TRAP; it is then held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_trap_code <= 2'd0;
    else if ((w_next == S_TRAP) && (r_state != S_TRAP)) r_trap_code <= w_tcode;
  end

`ifdef STACK_CTRL_PERF_EN
  logic        w_retire;
  logic [31:0] r_instret;

  assign w_retire  = (w_next == S_IF) && (r_state != S_IF);
  assign o_instret = r_instret;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end
`else
  assign o_instret = 32'd0;
`endif

  // Next-state and control decode; every output idles at 0 unless the state drives it.
  always_comb begin
    w_next      = r_state;
    w_tcode     = 2'd0;
    o_pc_next   = 1'b0;
    o_pc_jump   = 1'b0;
    o_pc_ld     = 1'b0;
    o_lord      = 1'b0;
    o_mr        = 1'b0;
    o_mw        = 1'b0;
    o_ir_ld     = 1'b0;
    o_stack_src = 2'd0;
    o_tos       = 1'b0;
    o_reg_dst   = 1'b0;
    o_push      = 1'b0;
    o_pop       = 1'b0;
    o_la        = 1'b0;
    o_lb        = 1'b0;
    o_ain       = 1'b0;
    o_bin       = 1'b0;
    o_alu_op    = 3'd0;
    o_halted    = 1'b0;
    o_trap      = 1'b0;

    case (r_state)
      S_IF: begin
        o_lord = 1'b1;
        o_mr   = 1'b1;
        o_ain  = 1'b1;
        if (i_mem_ready) begin
          o_ir_ld   = 1'b1;
          o_pc_ld   = 1'b1;
          o_pc_next = 1'b1;
          w_next    = S_ID;
        end else if (w_to_hit) begin
          w_next  = S_TRAP;
          w_tcode = 2'd3;
        end
      end
      S_ID: begin
        o_tos = 1'b1;
        o_la  = 1'b1;
        if (w_illegal) begin
          w_next  = S_TRAP;
          w_tcode = 2'd2;
        end else if (w_under) begin
          w_next  = S_TRAP;
          w_tcode = 2'd1;
        end else if (w_over) begin
          w_next  = S_TRAP;
          w_tcode = 2'd0;
        end else begin
          case (w_op4)
            4'd0, 4'd1, 4'd2, 4'd3: w_next = S_POPA;
            4'd4:                   w_next = S_POPN;
            4'd5:                   w_next = S_MRD;
            4'd6:                   w_next = S_MWR;
            4'd7:                   w_next = S_JMP;
            4'd8:                   w_next = S_JZ;
            4'd9:                   w_next = S_DUP;
            4'd15:                  w_next = S_HALT;
            default: begin
              w_next  = S_TRAP;
              w_tcode = 2'd2;
            end
          endcase
        end
      end
      S_POPA: begin
        o_pop  = 1'b1;
        w_next = S_SP;
      end
      S_SP: begin
        o_pop     = 1'b1;
        o_tos     = 1'b1;
        o_reg_dst = 1'b1;
        o_lb      = 1'b1;
        w_next    = S_ALU;
      end
      S_ALU: begin
        o_bin    = 1'b1;
        o_alu_op = {1'b0, i_opcode[1:0]};
        w_next   = S_SAVE;
      end
      S_POPN: begin
        o_pop  = 1'b1;
        w_next = S_NALU;
      end
      S_NALU: begin
        o_alu_op = 3'd4;
        w_next   = S_SAVE;
      end
      S_SAVE: begin
        o_push      = 1'b1;
        o_stack_src = 2'd1;
        w_next      = S_IF;
      end
      S_MRD: begin
        o_mr = 1'b1;
        if (i_mem_ready) begin
          o_push      = 1'b1;
          o_stack_src = 2'd0;
          w_next      = S_IF;
        end else if (w_to_hit) begin
          w_next  = S_TRAP;
          w_tcode = 2'd3;
        end
      end
      S_MWR: begin
        o_mw = 1'b1;
        if (i_mem_ready) begin
          o_pop  = 1'b1;
          w_next = S_IF;
        end else if (w_to_hit) begin
          w_next  = S_TRAP;
          w_tcode = 2'd3;
        end
      end
      S_JMP: begin
        o_pc_jump = 1'b1;
        o_pc_ld   = 1'b1;
        w_next    = S_IF;
      end
      S_JZ: begin
        o_pop = 1'b1;
        if (i_a_zero) begin
          o_pc_jump = 1'b1;
          o_pc_ld   = 1'b1;
        end
        w_next = S_IF;
      end
      S_DUP: begin
        o_push      = 1'b1;
        o_stack_src = 2'd2;
        w_next      = S_IF;
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      S_TRAP: begin
        o_trap = 1'b1;
      end
      default: begin
        w_next = S_IF;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl_mc.sv
// ============================================================================
// Module   : tb_stack_ctrl_mc
// Purpose  : Self-checking bench for stack_ctrl_mc (OPW=4, MEM_TO=4). A table
//            of per-cycle vectors walks the normal instruction flows; short
//            hand-written sequences cover traps, timeout, HALT and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_ctrl_mc;

  // Control bus bit positions (packed into a 24-bit compare word).
  localparam logic [23:0] B_PCN   = 24'h800000;
  localparam logic [23:0] B_PCJ   = 24'h400000;
  localparam logic [23:0] B_PCLD  = 24'h200000;
  localparam logic [23:0] B_LORD  = 24'h100000;
  localparam logic [23:0] B_MR    = 24'h080000;
  localparam logic [23:0] B_MW    = 24'h040000;
  localparam logic [23:0] B_IRLD  = 24'h020000;
  localparam logic [23:0] S_ALUV  = 24'h008000;
  localparam logic [23:0] S_AREG  = 24'h010000;
  localparam logic [23:0] B_TOS   = 24'h004000;
  localparam logic [23:0] B_RDST  = 24'h002000;
  localparam logic [23:0] B_PUSH  = 24'h001000;
  localparam logic [23:0] B_POP   = 24'h000800;
  localparam logic [23:0] B_LA    = 24'h000400;
  localparam logic [23:0] B_LB    = 24'h000200;
  localparam logic [23:0] B_AIN   = 24'h000100;
  localparam logic [23:0] B_BIN   = 24'h000080;
  localparam logic [23:0] OP_SUB  = 24'h000010;
  localparam logic [23:0] OP_OR   = 24'h000030;
  localparam logic [23:0] OP_NOT  = 24'h000040;
  localparam logic [23:0] B_HALT  = 24'h000008;
  localparam logic [23:0] B_TRAP  = 24'h000004;

  localparam logic [23:0] IF_W = B_LORD | B_MR | B_AIN;
  localparam logic [23:0] IF_F = IF_W | B_PCN | B_PCLD | B_IRLD;
  localparam logic [23:0] ID_E = B_TOS | B_LA;
  localparam logic [23:0] SP_E = B_POP | B_TOS | B_RDST | B_LB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic        mem_ready = 1'b0;
  logic        a_zero = 1'b0;
  logic        stk_empty = 1'b0;
  logic        stk_single = 1'b0;
  logic        stk_full = 1'b0;
  logic        pc_next, pc_jump, pc_ld, lord, mr, mw, ir_ld;
  logic [1:0]  stack_src;
  logic        tos, reg_dst, push, pop, la, lb, ain, bin;
  logic [2:0]  alu_op;
  logic        halted, trap;
  logic [1:0]  trap_code;
  logic [31:0] instret;
  logic [23:0] act;

  int checks   = 0;
  int failures = 0;

  stack_ctrl_mc #(.OPW(4), .MEM_TO(4)) dut (
    .clk(clk), .rst(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
    .i_a_zero(a_zero), .i_stk_empty(stk_empty), .i_stk_single(stk_single),
    .i_stk_full(stk_full), .o_pc_next(pc_next), .o_pc_jump(pc_jump),
    .o_pc_ld(pc_ld), .o_lord(lord), .o_mr(mr), .o_mw(mw), .o_ir_ld(ir_ld),
    .o_stack_src(stack_src), .o_tos(tos), .o_reg_dst(reg_dst), .o_push(push),
    .o_pop(pop), .o_la(la), .o_lb(lb), .o_ain(ain), .o_bin(bin),
    .o_alu_op(alu_op), .o_halted(halted), .o_trap(trap),
    .o_trap_code(trap_code), .o_instret(instret)
  );

  assign act = {pc_next, pc_jump, pc_ld, lord, mr, mw, ir_ld, stack_src,
                tos, reg_dst, push, pop, la, lb, ain, bin, alu_op,
                halted, trap, trap_code};

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        rdy;
    logic        az;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic [3:0] op, input logic rdy,
                     input logic az, input logic [23:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.rdy = rdy; v.az = az; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: ctrl got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_instret(input string n, input logic [31:0] exp);
    checks++;
    if (instret !== exp) begin
      failures++;
      $display("FAIL %s: instret got %0d expected %0d", n, instret, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare, wait for next falling edge.
  task automatic step(input string n, input logic [3:0] op, input logic rdy,
                      input logic az, input logic emp, input logic sgl,
                      input logic ful, input logic [23:0] exp);
    opcode = op; mem_ready = rdy; a_zero = az;
    stk_empty = emp; stk_single = sgl; stk_full = ful;
    #1;
    check(n, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = 4'd0; a_zero = 1'b0;
    stk_empty = 1'b0; stk_single = 1'b0; stk_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal flows, one record per cycle, stack deep enough for everything.
    add("if_stall",  4'd0, 1'b0, 1'b0, IF_W);
    add("add_if",    4'd0, 1'b1, 1'b0, IF_F);
    add("add_id",    4'd0, 1'b1, 1'b0, ID_E);
    add("add_popa",  4'd0, 1'b1, 1'b0, B_POP);
    add("add_sp",    4'd0, 1'b1, 1'b0, SP_E);
    add("add_alu",   4'd0, 1'b1, 1'b0, B_BIN);
    add("add_save",  4'd0, 1'b1, 1'b0, B_PUSH | S_ALUV);
    add("or_if",     4'd3, 1'b1, 1'b0, IF_F);
    add("or_id",     4'd3, 1'b1, 1'b0, ID_E);
    add("or_popa",   4'd3, 1'b1, 1'b0, B_POP);
    add("or_sp",     4'd3, 1'b1, 1'b0, SP_E);
    add("or_alu",    4'd3, 1'b1, 1'b0, B_BIN | OP_OR);
    add("or_save",   4'd3, 1'b1, 1'b0, B_PUSH | S_ALUV);
    add("not_if",    4'd4, 1'b1, 1'b0, IF_F);
    add("not_id",    4'd4, 1'b1, 1'b0, ID_E);
    add("not_popn",  4'd4, 1'b1, 1'b0, B_POP);
    add("not_nalu",  4'd4, 1'b1, 1'b0, OP_NOT);
    add("not_save",  4'd4, 1'b1, 1'b0, B_PUSH | S_ALUV);
    add("push_if",   4'd5, 1'b1, 1'b0, IF_F);
    add("push_id",   4'd5, 1'b1, 1'b0, ID_E);
    add("push_w1",   4'd5, 1'b0, 1'b0, B_MR);
    add("push_w2",   4'd5, 1'b0, 1'b0, B_MR);
    add("push_w3",   4'd5, 1'b0, 1'b0, B_MR);
    add("push_rdy",  4'd5, 1'b1, 1'b0, B_MR | B_PUSH);
    add("pop_if",    4'd6, 1'b1, 1'b0, IF_F);
    add("pop_id",    4'd6, 1'b1, 1'b0, ID_E);
    add("pop_mwr",   4'd6, 1'b1, 1'b0, B_MW | B_POP);
    add("jz1_if",    4'd8, 1'b1, 1'b1, IF_F);
    add("jz1_id",    4'd8, 1'b1, 1'b1, ID_E);
    add("jz1_taken", 4'd8, 1'b1, 1'b1, B_POP | B_PCJ | B_PCLD);
    add("jz0_if",    4'd8, 1'b1, 1'b0, IF_F);
    add("jz0_id",    4'd8, 1'b1, 1'b0, ID_E);
    add("jz0_not",   4'd8, 1'b1, 1'b0, B_POP);
    add("jmp_if",    4'd7, 1'b1, 1'b0, IF_F);
    add("jmp_id",    4'd7, 1'b1, 1'b0, ID_E);
    add("jmp_ex",    4'd7, 1'b1, 1'b0, B_PCJ | B_PCLD);
    add("dup_if",    4'd9, 1'b1, 1'b0, IF_F);
    add("dup_id",    4'd9, 1'b1, 1'b0, ID_E);
    add("dup_ex",    4'd9, 1'b1, 1'b0, B_PUSH | S_AREG);

    rst = 1'b1;
    #1;
    check("reset_state", IF_W);
    check_instret("reset_instret", 32'd0);
    do_reset();

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].op, tbl[i].rdy, tbl[i].az, 1'b0, 1'b0, 1'b0, tbl[i].exp);

`ifdef STACK_CTRL_PERF_EN
    check_instret("instret_after_table", 32'd9);
`else
    check_instret("instret_after_table", 32'd0);
`endif

    // Reset asserted in the middle of SP aborts to IF immediately.
    step("rs_if",   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IF_F);
    step("rs_id",   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ID_E);
    step("rs_popa", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_POP);
    mem_ready = 1'b1;
    #1;
    check("rs_sp", SP_E);
    #1;
    rst = 1'b1;
    #1;
    check("rs_async_if", IF_F);
    check_instret("rs_instret", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("rs_resume_if", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IF_F);
    step("rs_resume_id", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ID_E);

    // SUB with a single entry: underflow trap, sticky.
    do_reset();
    step("uf_if", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IF_F);
    step("uf_id", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ID_E);
    for (int k = 0; k < 3; k++)
      step("uf_trap", 4'd5, 1'(k[0]), 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP | 24'd1);

    // PUSH with full stack: overflow trap.
    do_reset();
    step("of_if",   4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IF_F);
    step("of_id",   4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ID_E);
    step("of_trap", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP);
    step("of_trap_sticky", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP);

    // Opcode 12 is illegal, and illegal wins over underflow.
    do_reset();
    step("ill_if",   4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IF_F);
    step("ill_id",   4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ID_E);
    step("ill_trap", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP | 24'd2);

    // Fetch stalled 4 cycles with MEM_TO=4: timeout trap.
    do_reset();
    for (int k = 0; k < 4; k++)
      step("to_stall", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IF_W);
    step("to_trap",        4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP | 24'd3);
    step("to_trap_sticky", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, B_TRAP | 24'd3);

    // Ready arriving on the 4th cycle completes normally.
    do_reset();
    for (int k = 0; k < 3; k++)
      step("to_edge_stall", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IF_W);
    step("to_edge_fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IF_F);
    step("to_edge_id",    4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ID_E);

    // HALT persists until reset.
    do_reset();
    step("halt_if", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IF_F);
    step("halt_id", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ID_E);
    for (int k = 0; k < 10; k++)
      step("halt_hold", 4'd0, 1'(k[0]), 1'b0, 1'b0, 1'b0, 1'b0, B_HALT);
    do_reset();
    step("halt_cleared", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IF_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_ctrl_mc.md
Name: stack_ctrl_mc

Overview:
Next-generation multicycle controller for the stack-based MIPS core. It decodes an OPW-bit opcode and steps a Moore/Mealy FSM that drives the PC, memory, stack and ALU datapath controls. Compared with the 3-bit controller, it adds a memory ready/timeout handshake, stack overflow/underflow checking, and NOT/DUP/HALT instructions. It also adds a sticky trap state.

Parameters:
OPW, 4, opcode width (>=4); any nonzero bit above bit 3 makes the opcode illegal.
MEM_TO, 16, stalled cycles allowed per memory access before a timeout trap; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
opcode  in  OPW  current IR opcode
mem_ready  in  1  memory completes access this cycle
a_zero  in  1  A register == 0
stk_empty, stk_single, stk_full  in  1 each  stack depth == 0 / == 1 / == max
pc_next, pc_jump, pc_ld, lord, mr, mw, ir_ld  out  1 each  PC/memory/IR controls
stack_src  out  2  stack push data: 0 = memory, 1 = ALU, 2 = A register
tos, reg_dst, push, pop, la, lb, ain, bin  out  1 each  stack/ALU operand controls
alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 not
halted, trap  out  1 each  sticky status
trap_code  out  2  0 overflow, 1 underflow, 2 illegal opcode, 3 memory timeout
instret  out  32  retired-instruction count (see optional feature)

Behaviour:
- Reset: state goes to IF and timeout counter to 0. halted = 0, trap = 0, trap_code = 0, instret = 0. Every control output defaults to 0 in every state unless listed below.
- Opcodes: 0–3 binary ALU (alu_op = opcode[1:0]), 4 NOT, 5 PUSH, 6 POP, 7 JMP, 8 JZ, 9 DUP, 15 HALT. 10–14 are illegal.
- IF:
  - Asserts lord = 1, mr = 1, ain = 1, bin = 0, alu_op = 0.
  - Holds in IF while mem_ready = 0.
  - In the cycle mem_ready = 1, additionally asserts ir_ld, pc_ld and pc_next (Mealy), then goes to ID.
- ID:
  - Asserts tos = 1, reg_dst = 0, la = 1.
  - Checks, in priority order:
    1. Illegal opcode → TRAP, code 2.
    2. Underflow → TRAP, code 1. Applies to: binary op with stk_empty or stk_single; NOT/POP/JZ/DUP with stk_empty.
    3. Overflow → TRAP, code 0. Applies to: PUSH/DUP with stk_full.
  - Otherwise dispatches: binary → POPA; NOT → POPN; PUSH → MRD; POP → MWR; JMP → JMP; JZ → JZ; DUP → DUP; HALT → HALT.
- POPA: pop = 1 → SP.
- SP: pop = 1, tos = 1, reg_dst = 1, lb = 1 → ALU.
- ALU: ain = 0, bin = 1, alu_op = opcode[1:0] → SAVE.
- POPN: pop = 1 → NALU.
- NALU: ain = 0, alu_op = 4 → SAVE.
- SAVE: push = 1, stack_src = 1 → IF.
- MRD:
  - Asserts lord = 0, mr = 1 and holds until mem_ready.
  - In the ready cycle asserts push = 1, stack_src = 0, then → IF.
- MWR:
  - Asserts lord = 0, mw = 1 and holds until mem_ready.
  - In the ready cycle asserts pop = 1, then → IF.
- JMP: pc_jump = 1, pc_ld = 1 → IF.
- JZ: pop = 1. If a_zero, also pc_jump = 1, pc_ld = 1. → IF.
- DUP: push = 1, stack_src = 2 → IF.
- HALT: halted = 1; stays until rst.
- TRAP: trap = 1 and trap_code is held; stays until rst. No memory or stack strobes are asserted.
- Timeout (IF/MRD/MWR):
  - The counter clears on entering the state.
  - It increments on each mem_ready = 0 cycle.
  - If the count == MEM_TO−1 and mem_ready = 0, the next state is TRAP, code 3.
  - mem_ready in that same cycle wins: normal completion, no trap.
- Latency with zero-wait memory: binary op 6 cycles; NOT 5; PUSH/POP/JMP/JZ/DUP 3.
- A retired instruction is counted on every transition back to IF.
- rst at any point aborts the current instruction immediately; outputs take their IF values asynchronously.

Optional Feature:
STACK_CTRL_PERF_EN:
- Defined: instret is a 32-bit counter. It increments on every retirement, wraps at 2^32, and is cleared by rst.
- Undefined: instret is tied to 0 and no counter flops are built.

Test Plan:
- ADD, stack [5, 3] (top 3), mem_ready always 1 → 6 cycles; sequence pop, pop + lb, alu_op = 0, push with stack_src = 1; back in IF.
- PUSH with mem_ready delayed 3 cycles → mr held 4 cycles in MRD; push asserted only in the 4th cycle.
- JZ with a_zero = 1, then JZ with a_zero = 0 → pc_jump + pc_ld only in the first; pop in both.
- SUB with stk_single = 1 → TRAP, trap_code = 1, sticky; PUSH with stk_full = 1 → trap_code = 0.
- Opcode 12 → trap_code = 2; MEM_TO = 4 with mem_ready stuck at 0 in IF → TRAP, code 3, on the 4th stalled cycle; ready on the 4th cycle → no trap.
- HALT → halted = 1 persists 10 cycles; rst asserted mid-SP → state IF, outputs at IF values; with the perf macro, instret resets to 0.
